// File: rtl/fma_job_scheduler.sv
// fma_job_scheduler: shares one fpfma_pipeline between two requesters.
// Round-robin issue (one job per cycle), an owner tag pipe that tracks the
// pipeline latency, and per-requester result FIFOs guarded by credits so a
// result always has a slot waiting for it.
module fma_job_scheduler #(
  parameter int WIDTH      = 32,
  parameter int LAT        = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r0_valid,
  output logic                  r0_ready,
  input  logic [19*WIDTH-1:0]   r0_ops,
  input  logic [1:0]            r0_rnd,
  input  logic                  r1_valid,
  output logic                  r1_ready,
  input  logic [19*WIDTH-1:0]   r1_ops,
  input  logic [1:0]            r1_rnd,
  output logic [9*WIDTH-1:0]    fma_A,
  output logic [9*WIDTH-1:0]    fma_B,
  output logic [WIDTH-1:0]      fma_C,
  output logic [1:0]            fma_rnd,
  input  logic [WIDTH-1:0]      fma_result,
  output logic                  o0_valid,
  input  logic                  o0_ready,
  output logic [WIDTH-1:0]      o0_data,
  output logic                  o1_valid,
  input  logic                  o1_ready,
  output logic [WIDTH-1:0]      o1_data,
  output logic                  busy
);

  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OPW = 19 * WIDTH;
  localparam logic [CW-1:0] CREDIT_MAX = CW'(FIFO_DEPTH);

  logic [1:0]       req_valid;
  logic [1:0]       eligible;
  logic [1:0]       grant;
  logic [1:0]       pop;
  logic [1:0]       fifo_wr;
  logic [1:0]       fifo_valid;
  logic [CW-1:0]    credit [2];
  logic [CW-1:0]    count [2];
  logic [PW-1:0]    wr_ptr [2];
  logic [PW-1:0]    rd_ptr [2];
  logic [WIDTH-1:0] mem [2][FIFO_DEPTH];
  logic             rr_last;      // 1: requester 1 held the most recent grant
  logic [LAT-1:0]   tag_valid;
  logic [LAT-1:0]   tag_owner;
  logic             align_valid;  // tag lined up with the current fma_result
  logic             align_owner;
  logic [OPW-1:0]   sel_ops;
  logic [1:0]       sel_rnd;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign req_valid = {r1_valid, r0_valid};

  // Eligibility: a request with at least one free result slot; nothing is granted in reset
  always_comb begin
    eligible = '0;
    for (int n = 0; n < 2; n++) begin
      eligible[n] = rst && req_valid[n] && (credit[n] != '0);
    end
  end

  // Round-robin choice: on contention the requester not granted last wins
  always_comb begin
    grant = '0;
    case (eligible)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr_last ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

  assign r0_ready = grant[0];
  assign r1_ready = grant[1];
  assign sel_ops  = grant[1] ? r1_ops : r0_ops;
  assign sel_rnd  = grant[1] ? r1_rnd : r0_rnd;

  assign pop     = {o1_valid & o1_ready, o0_valid & o0_ready};
  assign fifo_wr = {align_valid & align_owner, align_valid & ~align_owner};

  // FIFO occupancy flags
  always_comb begin
    fifo_valid = '0;
    for (int n = 0; n < 2; n++) begin
      fifo_valid[n] = (count[n] != '0);
    end
  end

  assign o0_valid = fifo_valid[0];
  assign o1_valid = fifo_valid[1];
  assign o0_data  = mem[0][rd_ptr[0]];
  assign o1_data  = mem[1][rd_ptr[1]];
  assign busy     = (|tag_valid) | align_valid | (|fifo_valid);

  // Issue register: loads the granted job, holds otherwise; pointer moves only on a grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_last <= 1'b1;
      fma_A   <= '0;
      fma_B   <= '0;
      fma_C   <= '0;
      fma_rnd <= '0;
    end else if (|grant) begin
      rr_last <= grant[1];
      fma_A   <= sel_ops[9*WIDTH-1:0];
      fma_B   <= sel_ops[18*WIDTH-1:9*WIDTH];
      fma_C   <= sel_ops[OPW-1:18*WIDTH];
      fma_rnd <= sel_rnd;
    end
  end

  // Owner tag pipe; the extra align stage matches the tag to fma_result LAT edges after issue
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_valid   <= '0;
      tag_owner   <= '0;
      align_valid <= 1'b0;
      align_owner <= 1'b0;
    end else begin
      tag_valid[0] <= |grant;
      tag_owner[0] <= grant[1];
      for (int i = 1; i < LAT; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_owner[i] <= tag_owner[i-1];
      end
      align_valid <= tag_valid[LAT-1];
      align_owner <= tag_owner[LAT-1];
    end
  end

  // Credits: one per free FIFO slot, taken on grant and returned on pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int n = 0; n < 2; n++) begin
        credit[n] <= CREDIT_MAX;
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        case ({grant[n], pop[n]})
          2'b10:   credit[n] <= credit[n] - CW'(1);
          2'b01:   credit[n] <= credit[n] + CW'(1);
          default: credit[n] <= credit[n];
        endcase
      end
    end
  end

  // Result FIFOs: registered storage, head word presented directly
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int n = 0; n < 2; n++) begin
        wr_ptr[n] <= '0;
        rd_ptr[n] <= '0;
        count[n]  <= '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
          mem[n][i] <= '0;
        end
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (fifo_wr[n]) begin
          mem[n][wr_ptr[n]] <= fma_result;
          wr_ptr[n]         <= ptr_inc(wr_ptr[n]);
        end
        if (pop[n]) begin
          rd_ptr[n] <= ptr_inc(rd_ptr[n]);
        end
        case ({fifo_wr[n], pop[n]})
          2'b10:   count[n] <= count[n] + CW'(1);
          2'b01:   count[n] <= count[n] - CW'(1);
          default: count[n] <= count[n];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fma_job_scheduler.sv
// Bench for fma_job_scheduler: a behavioural fpfma pipeline stand-in, a
// table of single jobs with hand-computed results, and hand-written
// sequences for arbitration, credit stalls and mid-flight reset.
module tb_fma_job_scheduler;

  localparam int W   = 32;
  localparam int LAT = 6;
  localparam logic [W-1:0] ONE = 32'h3f800000;

  logic             clk;
  logic             rst;
  logic             r0_valid, r0_ready, r1_valid, r1_ready;
  logic [19*W-1:0]  r0_ops, r1_ops;
  logic [1:0]       r0_rnd, r1_rnd;
  logic [9*W-1:0]   fma_A, fma_B;
  logic [W-1:0]     fma_C, fma_result;
  logic [1:0]       fma_rnd;
  logic             o0_valid, o0_ready, o1_valid, o1_ready;
  logic [W-1:0]     o0_data, o1_data;
  logic             busy;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] q0 [$];
  logic [W-1:0] q1 [$];
  logic [W-1:0] cur_exp0, cur_exp1;
  logic [W-1:0] pipe [LAT];
  int gseq [16];
  int gcount;

  typedef struct {
    int           req;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           n;
    logic [W-1:0] c;
    logic [1:0]   rnd;
    logic [W-1:0] exp;
  } vec_t;

  vec_t tbl [8];

  fma_job_scheduler #(.WIDTH(W), .LAT(LAT), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_ops(r0_ops), .r0_rnd(r0_rnd),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_ops(r1_ops), .r1_rnd(r1_rnd),
    .fma_A(fma_A), .fma_B(fma_B), .fma_C(fma_C), .fma_rnd(fma_rnd),
    .fma_result(fma_result),
    .o0_valid(o0_valid), .o0_ready(o0_ready), .o0_data(o0_data),
    .o1_valid(o1_valid), .o1_ready(o1_ready), .o1_data(o1_data),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic real f2r(input logic [W-1:0] x);
    logic [63:0] d;
    if (x[30:0] == '0) return 0.0;
    d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [W-1:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == '0) return '0;
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // Pipeline stand-in: sum(Ai*Bi)+C appears LAT edges after fma_* change
  always @(posedge clk) begin
    real s;
    s = f2r(fma_C);
    for (int i = 0; i < 9; i++) s = s + f2r(fma_A[i*W +: W]) * f2r(fma_B[i*W +: W]);
    pipe[0] <= r2f(s);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign fma_result = pipe[LAT-1];

  function automatic logic [W-1:0] p2(input int e);
    return {1'b0, 8'(127 + e), 23'd0};
  endfunction

  function automatic logic [19*W-1:0] make_ops(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input int n, input logic [W-1:0] c);
    logic [19*W-1:0] ops;
    ops = '0;
    for (int i = 0; i < n; i++) begin
      ops[i*W +: W]     = a;
      ops[(9+i)*W +: W] = b;
    end
    ops[18*W +: W] = c;
    return ops;
  endfunction

  task automatic chk(input string name, input logic [9*W-1:0] act, input logic [9*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: push expected result on each accepted job, compare on each pop
  always @(negedge clk) begin
    if (rst) begin
      if (r0_valid && r0_ready) q0.push_back(cur_exp0);
      if (r1_valid && r1_ready) q1.push_back(cur_exp1);
      if (o0_valid && o0_ready) begin
        if (q0.size() == 0) chk("sb0_unexpected", o0_data, '0 - 1);
        else chk("sb0_data", o0_data, q0.pop_front());
      end
      if (o1_valid && o1_ready) begin
        if (q1.size() == 0) chk("sb1_unexpected", o1_data, '0 - 1);
        else chk("sb1_data", o1_data, q1.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    q0.delete(); q1.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    r0_valid = 1'b0; r1_valid = 1'b0;
    o0_ready = 1'b1; o1_ready = 1'b1;
    while (busy && n < 80) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_idle"}, busy, 0);
    chk({name, "_q0_empty"}, q0.size(), 0);
    chk({name, "_q1_empty"}, q1.size(), 0);
    o0_ready = 1'b0; o1_ready = 1'b0;
  endtask

  task automatic run_single(input vec_t v);
    logic [19*W-1:0] ops;
    int cnt;
    ops = make_ops(v.a, v.b, v.n, v.c);
    @(posedge clk); #1;
    o0_ready = 1'b0; o1_ready = 1'b0;
    if (v.req == 0) begin
      r0_valid = 1'b1; r0_ops = ops; r0_rnd = v.rnd; cur_exp0 = v.exp;
    end else begin
      r1_valid = 1'b1; r1_ops = ops; r1_rnd = v.rnd; cur_exp1 = v.exp;
    end
    @(negedge clk);
    chk("single_ready", (v.req == 0) ? r0_ready : r1_ready, 1);
    @(posedge clk); #1;
    r0_valid = 1'b0; r1_valid = 1'b0;
    chk("single_fma_A", fma_A, ops[9*W-1:0]);
    chk("single_fma_B", fma_B, ops[18*W-1:9*W]);
    chk("single_fma_C", fma_C, v.c);
    chk("single_fma_rnd", fma_rnd, v.rnd);
    cnt = 0;
    while (!((v.req == 0) ? o0_valid : o1_valid) && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("single_latency", cnt, LAT + 1);
    chk("single_data", (v.req == 0) ? o0_data : o1_data, v.exp);
    if (v.req == 0) o0_ready = 1'b1; else o1_ready = 1'b1;
    @(posedge clk); #1;
    o0_ready = 1'b0; o1_ready = 1'b0;
    chk("single_popped", o0_valid | o1_valid, 0);
    chk("single_idle", busy, 0);
  endtask

  // Both requesters stream jobs; job i carries A1 = 2^(base+i), B1 = 1.0 so its result is A1
  task automatic feed(input int n0, input int n1, input int b0, input int b1,
                      input int o1_hold, input int budget, output int acc1_window,
                      output logic r1_ready_end);
    int i0, i1;
    i0 = 0; i1 = 0; gcount = 0; acc1_window = 0; r1_ready_end = 1'b1;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(posedge clk); #1;
      o0_ready = 1'b1;
      o1_ready = (cyc >= o1_hold);
      r0_valid = (i0 < n0);
      r0_ops   = make_ops(p2(b0 + i0), ONE, 1, '0);
      r0_rnd   = 2'b00;
      cur_exp0 = p2(b0 + i0);
      r1_valid = (i1 < n1);
      r1_ops   = make_ops(p2(b1 + i1), ONE, 1, '0);
      r1_rnd   = 2'b10;
      cur_exp1 = p2(b1 + i1);
      @(negedge clk);
      if (r0_valid && r0_ready) begin
        if (gcount < 16) gseq[gcount] = 0;
        gcount++; i0++;
      end
      if (r1_valid && r1_ready) begin
        if (gcount < 16) gseq[gcount] = 1;
        gcount++; i1++;
        if (cyc < o1_hold) acc1_window++;
      end
      if (cyc == o1_hold - 1) r1_ready_end = r1_ready;
      if (i0 == n0 && i1 == n1) break;
    end
    chk("feed_all_accepted", {i0[15:0], i1[15:0]}, {n0[15:0], n1[15:0]});
    @(posedge clk); #1;
  endtask

  initial begin
    int acc1, got, stale;
    logic r1_end, d0, d1;

    tbl[0] = '{0, 32'h3f800000, 32'h3f800000, 1, 32'h00000000, 2'b00, 32'h3f800000};
    tbl[1] = '{1, 32'h40000000, 32'h3f800000, 9, 32'h3f800000, 2'b01, 32'h41980000};
    tbl[2] = '{0, 32'h3f800000, 32'h3f800000, 9, 32'h00000000, 2'b10, 32'h41100000};
    tbl[3] = '{1, 32'h40000000, 32'h40000000, 9, 32'h3f800000, 2'b11, 32'h42140000};
    tbl[4] = '{0, 32'h40400000, 32'hbf800000, 1, 32'h3f000000, 2'b01, 32'hc0200000};
    tbl[5] = '{1, 32'h3f000000, 32'h3f000000, 1, 32'h00000000, 2'b00, 32'h3e800000};
    tbl[6] = '{0, 32'h3f800000, 32'h00000000, 9, 32'h00000000, 2'b10, 32'h00000000};
    tbl[7] = '{1, 32'h40400000, 32'h40400000, 9, 32'h00000000, 2'b01, 32'h42a20000};

    rst = 1'b0;
    r0_valid = 1'b1; r1_valid = 1'b0;
    r0_ops = make_ops(ONE, ONE, 9, ONE); r1_ops = '0;
    r0_rnd = 2'b11; r1_rnd = 2'b00;
    o0_ready = 1'b0; o1_ready = 1'b0;
    cur_exp0 = '0; cur_exp1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_fma_A", fma_A, 0);
    chk("reset_fma_C", fma_C, 0);
    chk("reset_fma_rnd", fma_rnd, 0);
    chk("reset_r0_ready", r0_ready, 0);
    chk("reset_o_valid", {o0_valid, o1_valid}, 0);
    chk("reset_busy", busy, 0);
    r0_valid = 1'b0;
    rst = 1'b1;

    // Single jobs, one at a time, with exact results and LAT+1 handshake-to-valid latency
    for (int i = 0; i < 8; i++) run_single(tbl[i]);

    // Continuous contention: grants alternate starting with r0 after reset
    do_reset();
    feed(8, 8, 0, 20, 0, 120, acc1, r1_end);
    for (int i = 0; i < 8; i++) chk("t2_grant_order", gseq[i], i % 2);
    drain("t2");

    // r1 consumer stalled for 10 cycles: exactly FIFO_DEPTH jobs accepted, then blocked
    feed(8, 6, -10, 30, 10, 150, acc1, r1_end);
    chk("t3_r1_accepted_window", acc1, 4);
    chk("t3_r1_ready_blocked", r1_end, 0);
    drain("t3");

    // Zero credits with a pop in the same cycle: grant waits one cycle
    got = 0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      @(posedge clk); #1;
      o0_ready = 1'b0;
      r0_valid = 1'b1;
      r0_ops = make_ops(p2(got + 5), ONE, 1, '0);
      cur_exp0 = p2(got + 5);
      @(negedge clk);
      if (r0_ready) got++;
    end
    chk("t4_fill", got, 4);
    @(posedge clk); #1;
    r0_ops = make_ops(p2(9), ONE, 1, '0);
    cur_exp0 = p2(9);
    repeat (12) @(posedge clk);
    #1;
    @(negedge clk);
    chk("t4_no_credit", r0_ready, 0);
    chk("t4_fifo_valid", o0_valid, 1);
    @(posedge clk); #1;
    o0_ready = 1'b1;
    @(negedge clk);
    chk("t4_pop_same_cycle", r0_ready, 0);
    @(posedge clk); #1;
    o0_ready = 1'b0;
    @(negedge clk);
    chk("t4_grant_next", r0_ready, 1);
    @(posedge clk); #1;
    drain("t4");

    // Reset with two jobs in flight: outputs clear at once, no stale results afterwards
    r0_valid = 1'b1; r0_ops = make_ops(p2(3), ONE, 1, ONE); r0_rnd = 2'b11; cur_exp0 = '0;
    r1_valid = 1'b1; r1_ops = make_ops(p2(4), ONE, 1, ONE); r1_rnd = 2'b10; cur_exp1 = '0;
    d0 = 1'b0; d1 = 1'b0;
    for (int cyc = 0; cyc < 6 && !(d0 && d1); cyc++) begin
      @(negedge clk);
      if (r0_ready) d0 = 1'b1;
      if (r1_ready) d1 = 1'b1;
      @(posedge clk); #1;
      if (d0) r0_valid = 1'b0;
      if (d1) r1_valid = 1'b0;
    end
    chk("t6_issued", {d0, d1}, 2'b11);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_busy_before", busy, 1);
    rst = 1'b0;
    #1;
    q0.delete(); q1.delete();
    chk("t6_fma_A", fma_A, 0);
    chk("t6_fma_B", fma_B, 0);
    chk("t6_fma_C", fma_C, 0);
    chk("t6_fma_rnd", fma_rnd, 0);
    chk("t6_o_valid", {o0_valid, o1_valid}, 0);
    chk("t6_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    stale = 0;
    for (int cyc = 0; cyc < LAT + 4; cyc++) begin
      @(posedge clk); #1;
      if (o0_valid || o1_valid) stale++;
    end
    chk("t6_no_stale", stale, 0);
    run_single(tbl[2]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
